// File: rtl/area1_pkg.sv
// Shared definitions for the area1 CUDB / config-RAM transfer blocks:
// record geometry, address widths, checksum width and the one-hot state set.
package area1_pkg;

  localparam int REC_BYTES = 16;
  localparam int REC_IDX_W = 4;
  localparam int CUDB_AW   = 13;
  localparam int CFG_AW    = 11;
  localparam int CSUM_W    = 8;

  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_READ   = 6'b000010,
    ST_DRAIN  = 6'b000100,
    ST_CHECK  = 6'b001000,
    ST_COMMIT = 6'b010000,
    ST_DONE   = 6'b100000
  } state_t;

  // Mod-2^CSUM_W running sum of record bytes.
  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                 input logic [7:0]        b);
    return acc + b;
  endfunction

endpackage

// File: rtl/area1_rd_lat_pipe.sv
// RD_LAT-deep valid shift register for CUDB readers. A read request entering
// on i_vld comes out on o_vld exactly when the RAM's dout carries its data.
// o_empty: no request in flight. o_tail_only: nothing in flight behind the
// stage currently at the output, so no byte arrives after this cycle.
module area1_rd_lat_pipe #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_vld,
  output logic o_vld,
  output logic o_empty,
  output logic o_tail_only
);

  logic [RD_LAT-1:0] pipe_q;
  logic [RD_LAT-1:0] pipe_d;
  logic              behind;

  // Advance every in-flight request one stage per cycle.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = i_vld;
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  // Stage register; cleared by reset so an abort discards pending returns.
  always_ff @(posedge clk) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  // Any request still upstream of the output stage.
  always_comb begin
    behind = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) behind = behind | pipe_q[i];
  end

  assign o_vld       = pipe_q[RD_LAT-1];
  assign o_empty     = ~|pipe_q;
  assign o_tail_only = ~behind;

endmodule

// File: rtl/area1_load_cfg.sv
// area1_load_cfg: copies one 16-byte record from the CUDB into the local
// 2Kx8 diag/config RAM on a start pulse.
// Build option CFG_CHECKSUM_EN: buffer the record, verify byte 15 equals the
// mod-256 sum of bytes 0..14, and write the RAM only if it matches (o_err
// flags a mismatch). Without it, bytes are written through as they return.
// Handshake: i_start is a one-cycle request taken only in IDLE (o_busy low);
// o_done pulses for one cycle when the transfer ends, and o_err is valid with
// it and held until the next accepted start. om_dbg_state shows the FSM state.
module area1_load_cfg
  import area1_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [9:0]         im_base_addr,
  input  logic [6:0]         im_dst_page,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic               o_cudb_rden,
  output logic [CUDB_AW-1:0] om_cudb_addr,
  input  logic [7:0]         im_cudb_dout,
  output logic               o_cfg_wren,
  output logic [CFG_AW-1:0]  om_cfg_addr,
  output logic [7:0]         om_cfg_din,
  output logic [5:0]         om_dbg_state
);

  state_t               state_q, state_d;
  logic [8:0]           base_q, base_d;
  logic [6:0]           page_q, page_d;
  logic [REC_IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [REC_IDX_W-1:0] cap_idx_q, cap_idx_d;
  logic                 start_acc;
  logic                 pipe_vld, pipe_empty, pipe_tail;
  logic                 unused_ok;

`ifdef CFG_CHECKSUM_EN
  logic [7:0]           buf_q [REC_BYTES];
  logic [7:0]           buf_d [REC_BYTES];
  logic [REC_IDX_W-1:0] cm_idx_q, cm_idx_d;
  logic                 err_q, err_d;
  logic [CSUM_W-1:0]    csum;
`else
  logic                 wr_en_q, wr_en_d;
  logic [CFG_AW-1:0]    wr_addr_q, wr_addr_d;
  logic [7:0]           wr_data_q, wr_data_d;
`endif

  assign start_acc = (state_q == ST_IDLE) && i_start;

  area1_rd_lat_pipe #(.RD_LAT(RD_LAT)) u_rd_lat_pipe (
    .clk         (clk),
    .rst         (rst),
    .i_vld       (o_cudb_rden),
    .o_vld       (pipe_vld),
    .o_empty     (pipe_empty),
    .o_tail_only (pipe_tail)
  );

`ifdef CFG_CHECKSUM_EN
  // Sum of bytes 0..14; compared against byte 15 in CHECK.
  always_comb begin
    csum = '0;
    for (int i = 0; i < REC_BYTES - 1; i++) csum = csum_add(csum, buf_q[i]);
  end
  assign unused_ok = ^{im_base_addr[9], pipe_empty};
`else
  assign unused_ok = ^{im_base_addr[9], pipe_tail};
`endif

  // Next-state logic and transfer-control registers.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    page_d   = page_q;
    rd_idx_d = rd_idx_q;
`ifdef CFG_CHECKSUM_EN
    cm_idx_d = cm_idx_q;
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          base_d   = im_base_addr[8:0];
          page_d   = im_dst_page;
          rd_idx_d = '0;
`ifdef CFG_CHECKSUM_EN
          err_d    = 1'b0;
`endif
          state_d  = ST_READ;
        end
      end
      ST_READ: begin
        rd_idx_d = rd_idx_q + 1'b1;
        if (rd_idx_q == 4'd15) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
`ifdef CFG_CHECKSUM_EN
        // Last byte lands in the buffer this cycle, so CHECK can follow.
        if (pipe_tail) state_d = ST_CHECK;
`else
        // Wait until the last write-through has been presented.
        if (pipe_empty) state_d = ST_DONE;
`endif
      end
`ifdef CFG_CHECKSUM_EN
      ST_CHECK: begin
        if (csum == buf_q[REC_BYTES-1]) begin
          cm_idx_d = '0;
          state_d  = ST_COMMIT;
        end else begin
          err_d    = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_COMMIT: begin
        cm_idx_d = cm_idx_q + 1'b1;
        if (cm_idx_q == 4'd15) state_d = ST_DONE;
      end
`endif
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Return path: count returned bytes and capture or forward each one.
  always_comb begin
    cap_idx_d = cap_idx_q;
    if (start_acc)     cap_idx_d = '0;
    else if (pipe_vld) cap_idx_d = cap_idx_q + 1'b1;
`ifdef CFG_CHECKSUM_EN
    buf_d = buf_q;
    if (pipe_vld) buf_d[cap_idx_q] = im_cudb_dout;
`else
    wr_en_d   = pipe_vld;
    wr_addr_d = pipe_vld ? {page_q, cap_idx_q} : '0;
    wr_data_d = pipe_vld ? im_cudb_dout : '0;
`endif
  end

  // Control and output registers; synchronous reset aborts to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      page_q    <= '0;
      rd_idx_q  <= '0;
      cap_idx_q <= '0;
`ifdef CFG_CHECKSUM_EN
      cm_idx_q  <= '0;
      err_q     <= 1'b0;
`else
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      page_q    <= page_d;
      rd_idx_q  <= rd_idx_d;
      cap_idx_q <= cap_idx_d;
`ifdef CFG_CHECKSUM_EN
      cm_idx_q  <= cm_idx_d;
      err_q     <= err_d;
`else
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`endif
    end
  end

`ifdef CFG_CHECKSUM_EN
  // Record buffer; contents are don't-care until filled, so no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign o_err       = err_q;
  assign o_cfg_wren  = (state_q == ST_COMMIT);
  assign om_cfg_addr = o_cfg_wren ? {page_q, cm_idx_q} : '0;
  assign om_cfg_din  = o_cfg_wren ? buf_q[cm_idx_q] : '0;
`else
  assign o_err       = 1'b0;
  assign o_cfg_wren  = wr_en_q;
  assign om_cfg_addr = wr_addr_q;
  assign om_cfg_din  = wr_data_q;
`endif

  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = (state_q == ST_DONE);
  assign o_cudb_rden  = (state_q == ST_READ);
  assign om_cudb_addr = o_cudb_rden ? {base_q, rd_idx_q} : '0;
  assign om_dbg_state = state_q;

endmodule

// File: tb/tb_area1_load_cfg.sv
// Bench for area1_load_cfg. Two instances run side by side on the same
// stimulus: RD_LAT=2 (index 0) and RD_LAT=4 (index 1), each with its own
// CUDB latency model. Expectations follow the build (CFG_CHECKSUM_EN or not).
module tb_area1_load_cfg;
  import area1_pkg::*;

`ifdef CFG_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        i_start = 1'b0;
  logic [9:0]  base_in = '0;
  logic [6:0]  page_in = '0;
  logic        busy [2];
  logic        done [2];
  logic        err  [2];
  logic        rden [2];
  logic        wren [2];
  logic [12:0] cudb_addr [2];
  logic [7:0]  cudb_dout [2];
  logic [10:0] cfg_addr  [2];
  logic [7:0]  cfg_din   [2];
  logic [5:0]  dbg       [2];

  area1_load_cfg #(.RD_LAT(2)) dut_l2 (
    .clk(clk), .rst(rst), .i_start(i_start), .im_base_addr(base_in), .im_dst_page(page_in),
    .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0]), .o_cudb_rden(rden[0]),
    .om_cudb_addr(cudb_addr[0]), .im_cudb_dout(cudb_dout[0]), .o_cfg_wren(wren[0]),
    .om_cfg_addr(cfg_addr[0]), .om_cfg_din(cfg_din[0]), .om_dbg_state(dbg[0])
  );

  area1_load_cfg #(.RD_LAT(4)) dut_l4 (
    .clk(clk), .rst(rst), .i_start(i_start), .im_base_addr(base_in), .im_dst_page(page_in),
    .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1]), .o_cudb_rden(rden[1]),
    .om_cudb_addr(cudb_addr[1]), .im_cudb_dout(cudb_dout[1]), .o_cfg_wren(wren[1]),
    .om_cfg_addr(cfg_addr[1]), .om_cfg_din(cfg_din[1]), .om_dbg_state(dbg[1])
  );

  // ---------------- CUDB models (fixed read latency) ----------------
  logic [7:0]  cudb_mem [0:8191];
  logic [13:0] rp2 [0:1];
  logic [13:0] rp4 [0:3];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) rp2[i] <= '0;
      for (int i = 0; i < 4; i++) rp4[i] <= '0;
    end else begin
      rp2[0] <= {rden[0], cudb_addr[0]};
      rp2[1] <= rp2[0];
      rp4[0] <= {rden[1], cudb_addr[1]};
      for (int i = 1; i < 4; i++) rp4[i] <= rp4[i-1];
    end
  end

  assign cudb_dout[0] = rp2[1][13] ? cudb_mem[rp2[1][12:0]] : 8'hA5;
  assign cudb_dout[1] = rp4[3][13] ? cudb_mem[rp4[3][12:0]] : 8'hA5;

  // ---------------- scoreboard ----------------
  logic [29:0] exp_rd_q [$];  // {dut, cycle[15:0], cudb addr[12:0]}
  logic [35:0] exp_wr_q [$];  // {dut, cycle[15:0], cfg addr[10:0], data[7:0]}
  logic [17:0] exp_dn_q [$];  // {dut, cycle[15:0], err}
  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;
  bit last_err = 1'b0;

  task automatic check(input bit ok, input string name, input int d,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s dut%0d @cycle %0d: got 0x%0h, expected 0x%0h", name, d, cyc, act, exp);
    end
  endtask

  function automatic bit pending();
    return (exp_rd_q.size() + exp_wr_q.size() + exp_dn_q.size()) != 0;
  endfunction

  task automatic mon_dut(input int d);
    int idx;
    logic [15:0] c16;
    c16 = cyc[15:0];
    if (rden[d]) begin
      idx = -1;
      foreach (exp_rd_q[i]) if (idx < 0 && exp_rd_q[i][29] == d[0]) idx = i;
      if (idx < 0) check(1'b0, "unexpected_read", d, {35'd0, c16, cudb_addr[d]}, 64'd0);
      else begin
        check(exp_rd_q[idx][28:0] == {c16, cudb_addr[d]}, "read_cycle_addr", d,
              {35'd0, c16, cudb_addr[d]}, {35'd0, exp_rd_q[idx][28:0]});
        exp_rd_q.delete(idx);
      end
    end else check(cudb_addr[d] == '0, "cudb_addr_idle", d, {51'd0, cudb_addr[d]}, 64'd0);

    if (wren[d]) begin
      idx = -1;
      foreach (exp_wr_q[i]) if (idx < 0 && exp_wr_q[i][35] == d[0]) idx = i;
      if (idx < 0) check(1'b0, "unexpected_write", d, {29'd0, c16, cfg_addr[d], cfg_din[d]}, 64'd0);
      else begin
        check(exp_wr_q[idx][34:0] == {c16, cfg_addr[d], cfg_din[d]}, "write_cycle_addr_data", d,
              {29'd0, c16, cfg_addr[d], cfg_din[d]}, {29'd0, exp_wr_q[idx][34:0]});
        exp_wr_q.delete(idx);
      end
    end else check({cfg_addr[d], cfg_din[d]} == '0, "cfg_idle", d, {45'd0, cfg_addr[d], cfg_din[d]}, 64'd0);

    if (done[d]) begin
      idx = -1;
      foreach (exp_dn_q[i]) if (idx < 0 && exp_dn_q[i][17] == d[0]) idx = i;
      if (idx < 0) check(1'b0, "unexpected_done", d, {47'd0, c16, err[d]}, 64'd0);
      else begin
        check(exp_dn_q[idx][16:0] == {c16, err[d]}, "done_cycle_err", d,
              {47'd0, c16, err[d]}, {47'd0, exp_dn_q[idx][16:0]});
        exp_dn_q.delete(idx);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) for (int d = 0; d < 2; d++) mon_dut(d);
  end

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [9:0] base;
    logic [6:0] page;
    logic [7:0] seed;     // bytes 0..14 = seed + k
    logic [7:0] b15;
    bit         exp_err;  // checksum verdict (checksum build)
    int         done_cs;  // done offset at RD_LAT=2, checksum build
    bit         glitch;   // extra i_start pulses at T+5 and T+17
  } vec_t;

  vec_t vecs [8];

  task automatic check_quiet(input string name);
    for (int d = 0; d < 2; d++) begin
      check({busy[d], done[d], err[d], rden[d], wren[d]} == 5'b0, {name, "_ctl"}, d,
            {59'd0, busy[d], done[d], err[d], rden[d], wren[d]}, 64'd0);
      check({cudb_addr[d], cfg_addr[d], cfg_din[d]} == '0, {name, "_bus"}, d,
            {32'd0, cudb_addr[d], cfg_addr[d], cfg_din[d]}, 64'd0);
      check(dbg[d] == ST_IDLE, {name, "_state"}, d, {58'd0, dbg[d]}, {58'd0, ST_IDLE});
    end
  endtask

  task automatic load_record(input vec_t v, output logic [7:0] by [16]);
    for (int k = 0; k < 16; k++) begin
      by[k] = (k < 15) ? v.seed + k[7:0] : v.b15;
      cudb_mem[{v.base[8:0], k[3:0]}] = by[k];
    end
  endtask

  task automatic drive_start(input vec_t v, output int t);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check(!busy[d], "idle_before_start", d, {63'd0, busy[d]}, 64'd0);
      check(err[d] == last_err, "err_hold", d, {63'd0, err[d]}, {63'd0, last_err});
    end
    i_start = 1'b1;
    base_in = v.base;
    page_in = v.page;
    t = cyc;
  endtask

  task automatic run_xfer(input vec_t v);
    logic [7:0] by [16];
    int t, lat, td;
    load_record(v, by);
    drive_start(v, t);
    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? 2 : 4;
      for (int k = 0; k < 16; k++)
        exp_rd_q.push_back({d[0], 16'(t + 1 + k), v.base[8:0], k[3:0]});
      if (!CS) begin
        for (int k = 0; k < 16; k++)
          exp_wr_q.push_back({d[0], 16'(t + 2 + k + lat), v.page, k[3:0], by[k]});
        td = t + 18 + lat;
        exp_dn_q.push_back({d[0], 16'(td), 1'b0});
      end else begin
        if (!v.exp_err)
          for (int k = 0; k < 16; k++)
            exp_wr_q.push_back({d[0], 16'(t + 18 + lat + k), v.page, k[3:0], by[k]});
        td = t + v.done_cs + (lat - 2);
        exp_dn_q.push_back({d[0], 16'(td), v.exp_err});
      end
    end
    last_err = CS ? v.exp_err : 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      i_start = v.glitch && (c == 5 || c == 17);
      base_in = 10'($urandom_range(0, 1023));
      page_in = 7'($urandom_range(0, 127));
    end
    i_start = 1'b0;
    #1;
    for (int i = 0; i < 60 && pending(); i++) begin
      @(negedge clk);
      #1;
    end
    if (pending()) begin
      check(1'b0, "transfer_timeout", 0, 64'(exp_rd_q.size() + exp_wr_q.size() + exp_dn_q.size()), 64'd0);
      exp_rd_q.delete();
      exp_wr_q.delete();
      exp_dn_q.delete();
    end
  endtask

  // Start a transfer, assert rst at T+8, expect an immediate quiet IDLE.
  task automatic reset_abort();
    vec_t v;
    logic [7:0] by [16];
    int t, lat;
    v = '{10'h123, 7'h2A, 8'h40, 8'h00, 1'b1, 20, 1'b0};
    load_record(v, by);
    drive_start(v, t);
    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? 2 : 4;
      for (int k = 0; k < 8; k++)
        exp_rd_q.push_back({d[0], 16'(t + 1 + k), v.base[8:0], k[3:0]});
      if (!CS)
        for (int k = 0; t + 2 + k + lat <= t + 8; k++)
          exp_wr_q.push_back({d[0], 16'(t + 2 + k + lat), v.page, k[3:0], by[k]});
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      rst     = (c == 8);
    end
    @(negedge clk);
    rst = 1'b0;
    check_quiet("after_abort");
    #1;
    check(!pending(), "abort_events_seen", 0,
          64'(exp_rd_q.size() + exp_wr_q.size() + exp_dn_q.size()), 64'd0);
    exp_rd_q.delete();
    exp_wr_q.delete();
    exp_dn_q.delete();
    last_err = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] s, sd;
    bit pass;
    vecs[0] = '{10'h005, 7'h12, 8'h00, 8'h0F, 1'b1, 20, 1'b0};
    vecs[1] = '{10'h006, 7'h13, 8'h01, 8'h78, 1'b0, 36, 1'b0};
    vecs[2] = '{10'h007, 7'h14, 8'h01, 8'h77, 1'b1, 20, 1'b0};
    vecs[3] = '{10'h3FF, 7'h7F, 8'hF0, 8'h79, 1'b0, 36, 1'b0};
    vecs[4] = '{10'h205, 7'h00, 8'h80, 8'hE9, 1'b0, 36, 1'b1};
    vecs[5] = '{10'h010, 7'h55, 8'h10, 8'h00, 1'b1, 20, 1'b1};
    for (int r = 6; r < 8; r++) begin
      sd = 8'($urandom_range(0, 255));
      s  = '0;
      for (int k = 0; k < 15; k++) s = s + sd + k[7:0];
      pass = 1'($urandom_range(0, 1));
      vecs[r] = '{10'($urandom_range(0, 1023)), 7'($urandom_range(0, 127)), sd,
                  pass ? s : (s ^ 8'h01), !pass, pass ? 36 : 20, 1'b0};
    end

    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst    = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 4; i++) run_xfer(vecs[i]);
    reset_abort();
    for (int i = 4; i < 8; i++) run_xfer(vecs[i]);

    repeat (3) @(negedge clk);
    check_quiet("final_idle_err_clear_pending");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
